galois_lfsr_checker: RTL and testbench



---
 rtl/galois_lfsr_checker.sv | 138 +++++++++++++
 tb/tb_galois_lfsr_checker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/galois_lfsr_checker.sv
// galois_lfsr_checker: receive-side PRBS checker for galois_lfsr words.
// Seeds a local predictor from the incoming stream and declares lock after
// LOCK_COUNT consecutive correct predictions. Once locked, it flywheels on its
// own predictor and counts mismatched words. It drops lock after
// UNLOCK_COUNT consecutive misses.
module galois_lfsr_checker #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-2:0] TAPS         = 7'b0111000,
  parameter int               LOCK_COUNT   = 4,
  parameter int               UNLOCK_COUNT = 4,
  parameter int               COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   data_valid,
  input  logic [WIDTH-1:0]       data,
  input  logic                   clear_errors,
  output logic                   locked,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic [WIDTH-1:0]       expected
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  // One Galois LFSR step, identical to the generator's update.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    lfsr_step = {v[0], ({(WIDTH-1){v[0]}} & TAPS) ^ v[WIDTH-1:1]};
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + 1'b1;
  endfunction

  // Stage p0 is the combinational next-state; stage p1 is the registered state.
  state_t                 state_p0, state_p1;
  logic [WIDTH-1:0]       pred_p0, pred_p1;
  logic [MATCH_W-1:0]     match_p0, match_p1;
  logic [MISS_W-1:0]      miss_p0, miss_p1;
  logic                   err_p0, err_p1;
  logic [COUNT_WIDTH-1:0] cnt_p0, cnt_p1;
  logic [MATCH_W-1:0]     match_inc;
  logic [MISS_W-1:0]      miss_inc;
  logic [COUNT_WIDTH-1:0] cnt_base;

  // State register: synchronous active-low reset overrides everything.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_p1 <= UNLOCKED;
      pred_p1  <= '0;
      match_p1 <= '0;
      miss_p1  <= '0;
      err_p1   <= 1'b0;
      cnt_p1   <= '0;
    end else begin
      state_p1 <= state_p0;
      pred_p1  <= pred_p0;
      match_p1 <= match_p0;
      miss_p1  <= miss_p0;
      err_p1   <= err_p0;
      cnt_p1   <= cnt_p0;
    end
  end

  // Next-state logic: acquisition reseeds from data, lock flywheels on pred.
  always_comb begin
    state_p0  = state_p1;
    pred_p0   = pred_p1;
    match_p0  = match_p1;
    miss_p0   = miss_p1;
    err_p0    = 1'b0;
    match_inc = match_p1 + 1'b1;
    miss_inc  = miss_p1 + 1'b1;
    // A clear on the same edge as a counted miss leaves exactly that miss.
    cnt_base  = clear_errors ? '0 : cnt_p1;
    cnt_p0    = cnt_base;
    if (data_valid) begin
      case (state_p1)
        UNLOCKED: begin
          // Zero is the LFSR lockup value and can never be a valid seed.
          if (data != '0) begin
            pred_p0  = lfsr_step(data);
            match_p0 = '0;
            state_p0 = ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (data == pred_p1) begin
            pred_p0  = lfsr_step(data);
            match_p0 = match_inc;
            if (match_inc == MATCH_LAST) begin
              state_p0 = LOCKED;
              miss_p0  = '0;
            end
          end else if (data != '0) begin
            pred_p0  = lfsr_step(data);
            match_p0 = '0;
          end else begin
            state_p0 = UNLOCKED;
          end
        end
        LOCKED: begin
          pred_p0 = lfsr_step(pred_p1);
          if (data != pred_p1) begin
            err_p0  = 1'b1;
            cnt_p0  = sat_inc(cnt_base);
            miss_p0 = miss_inc;
            if (miss_inc == MISS_LAST) begin
              state_p0 = UNLOCKED;
            end
          end else begin
            miss_p0 = '0;
          end
        end
        default: state_p0 = UNLOCKED;
      endcase
    end
  end

  // Outputs come straight from the registered state.
  always_comb begin
    locked      = (state_p1 == LOCKED);
    error       = err_p1;
    error_count = cnt_p1;
    expected    = pred_p1;
  end

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Testbench for galois_lfsr_checker: a default instance and a 2-bit-counter
// instance driven with the same stream, checked against a behavioural model,
// a table of hand-derived vectors and a few directed sequences.
module tb_galois_lfsr_checker;

  localparam logic [6:0] TAPS = 7'b0111000;

  logic        clock;
  logic        resetn;
  logic        data_valid;
  logic [7:0]  data;
  logic        clear_errors;

  logic        dut_locked, dut_error;
  logic [15:0] dut_count;
  logic [7:0]  dut_expected;
  logic        sat_locked, sat_error;
  logic [1:0]  sat_count;
  logic [7:0]  sat_expected;

  int n_cmp  = 0;
  int n_fail = 0;

  galois_lfsr_checker dut (
    .clock(clock), .resetn(resetn), .data_valid(data_valid), .data(data),
    .clear_errors(clear_errors), .locked(dut_locked), .error(dut_error),
    .error_count(dut_count), .expected(dut_expected)
  );

  galois_lfsr_checker #(.COUNT_WIDTH(2)) dut_s (
    .clock(clock), .resetn(resetn), .data_valid(data_valid), .data(data),
    .clear_errors(clear_errors), .locked(sat_locked), .error(sat_error),
    .error_count(sat_count), .expected(sat_expected)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference LFSR step written as shift-and-conditional-xor.
  function automatic logic [7:0] mstep(input logic [7:0] v);
    mstep = (v >> 1) ^ (v[0] ? {1'b1, TAPS} : 8'h00);
  endfunction

  // Behavioural model state, one slot per instance (0: 16-bit, 1: 2-bit count).
  logic       m_locked [2];
  logic       m_acq    [2];
  logic [7:0] m_pred   [2];
  int         m_run    [2];
  int         m_miss   [2];
  int         m_cnt    [2];
  logic       m_err    [2];

  task automatic model_edge(input logic v, input logic [7:0] d, input logic c, input logic rn);
    for (int k = 0; k < 2; k++) begin
      int cmax;
      cmax = (k == 0) ? 65535 : 3;
      if (!rn) begin
        m_locked[k] = 0; m_acq[k] = 0; m_pred[k] = 0;
        m_run[k] = 0; m_miss[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      end else begin
        m_err[k] = 0;
        if (c) m_cnt[k] = 0;
        if (v) begin
          if (m_locked[k]) begin
            if (d != m_pred[k]) begin
              m_err[k] = 1;
              m_cnt[k] = (m_cnt[k] < cmax) ? m_cnt[k] + 1 : cmax;
              m_miss[k]++;
              if (m_miss[k] == 4) m_locked[k] = 0;
            end else begin
              m_miss[k] = 0;
            end
            m_pred[k] = mstep(m_pred[k]);
          end else if (m_acq[k]) begin
            if (d == m_pred[k]) begin
              m_pred[k] = mstep(d);
              m_run[k]++;
              if (m_run[k] == 4) begin
                m_locked[k] = 1; m_acq[k] = 0; m_miss[k] = 0;
              end
            end else if (d != 8'h00) begin
              m_pred[k] = mstep(d);
              m_run[k] = 0;
            end else begin
              m_acq[k] = 0;
            end
          end else if (d != 8'h00) begin
            m_pred[k] = mstep(d);
            m_run[k] = 0;
            m_acq[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic check_model();
    chk("m_locked",   32'(dut_locked),   32'(m_locked[0]));
    chk("m_error",    32'(dut_error),    32'(m_err[0]));
    chk("m_count",    32'(dut_count),    32'(m_cnt[0]));
    chk("m_expected", 32'(dut_expected), 32'(m_pred[0]));
    chk("s_locked",   32'(sat_locked),   32'(m_locked[1]));
    chk("s_error",    32'(sat_error),    32'(m_err[1]));
    chk("s_count",    32'(sat_count),    32'(m_cnt[1]));
    chk("s_expected", 32'(sat_expected), 32'(m_pred[1]));
  endtask

  // Apply one cycle of inputs, advance the model on the edge, check 1ns later.
  task automatic cyc(input logic v, input logic [7:0] d, input logic c, input logic rn);
    data_valid   = v;
    data         = d;
    clear_errors = c;
    resetn       = rn;
    @(posedge clock);
    model_edge(v, d, c, rn);
    #1;
    check_model();
  endtask

  typedef struct packed {
    logic        vld;
    logic [7:0]  d;
    logic        clr;
    logic        lk;
    logic        er;
    logic [15:0] cnt;
    logic [7:0]  ex;
  } vec_t;

  vec_t tbl [18];

  initial begin
    logic [7:0] gen;
    logic [7:0] acq_seq [7];
    int pulses;

    tbl[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 8'hB8};
    tbl[1]  = '{1'b1, 8'hB8, 1'b0, 1'b0, 1'b0, 16'd0, 8'h5C};
    tbl[2]  = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 16'd0, 8'h2E};
    tbl[3]  = '{1'b1, 8'h2E, 1'b0, 1'b0, 1'b0, 16'd0, 8'h17};
    tbl[4]  = '{1'b1, 8'h17, 1'b0, 1'b1, 1'b0, 16'd0, 8'hB3};
    tbl[5]  = '{1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 16'd1, 8'hE1};
    tbl[6]  = '{1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, 16'd1, 8'hC8};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'd0, 8'hC8};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd1, 8'h64};
    tbl[9]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 16'd2, 8'h32};
    tbl[10] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 16'd3, 8'h19};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'd4, 8'hB4};
    tbl[12] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 16'd4, 8'hB4};
    tbl[13] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd4, 8'hB8};
    tbl[14] = '{1'b1, 8'hB8, 1'b0, 1'b0, 1'b0, 16'd4, 8'h5C};
    tbl[15] = '{1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 16'd4, 8'h2E};
    tbl[16] = '{1'b1, 8'h2E, 1'b0, 1'b0, 1'b0, 16'd4, 8'h17};
    tbl[17] = '{1'b1, 8'h17, 1'b0, 1'b1, 1'b0, 16'd4, 8'hB3};

    data_valid = 1'b0; data = 8'h00; clear_errors = 1'b0; resetn = 1'b0;

    // Reset state
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_locked",   32'(dut_locked),   32'd0);
    chk("rst_error",    32'(dut_error),    32'd0);
    chk("rst_count",    32'(dut_count),    32'd0);
    chk("rst_expected", 32'(dut_expected), 32'd0);

    // Lock acquisition, single flywheel error, clear, loss of lock, relock
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].vld, tbl[i].d, tbl[i].clr, 1'b1);
      chk($sformatf("tbl%0d_locked", i),   32'(dut_locked),   32'(tbl[i].lk));
      chk($sformatf("tbl%0d_error", i),    32'(dut_error),    32'(tbl[i].er));
      chk($sformatf("tbl%0d_count", i),    32'(dut_count),    32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_expected", i), 32'(dut_expected), 32'(tbl[i].ex));
    end

    // Zero ignored in UNLOCKED, mismatch reseeds ACQUIRE without counting
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    chk("zero_locked",   32'(dut_locked),   32'd0);
    chk("zero_expected", 32'(dut_expected), 32'd0);
    acq_seq = '{8'h01, 8'hB8, 8'hAA, 8'h17, 8'hB3, 8'hE1, 8'hC8};
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, acq_seq[i], 1'b0, 1'b1);
      chk("acq_not_locked", 32'(dut_locked), 32'd0);
      chk("acq_no_error",   32'(dut_error),  32'd0);
    end
    cyc(1'b1, 8'h64, 1'b0, 1'b1);
    chk("acq_locked",   32'(dut_locked),   32'd1);
    chk("acq_expected", 32'(dut_expected), 32'h32);
    chk("acq_count",    32'(dut_count),    32'd0);
    gen = 8'h32;

    // Saturation on the 2-bit counter, then clear on the same edge as a miss
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, (i % 2 == 0) ? (gen ^ 8'h5A) : gen, 1'b0, 1'b1);
      gen = mstep(gen);
      pulses += int'(sat_error);
    end
    chk("sat_count",  32'(sat_count),  32'd3);
    chk("sat_pulses", 32'(pulses),     32'd5);
    chk("sat_locked", 32'(sat_locked), 32'd1);
    chk("full_count", 32'(dut_count),  32'd5);
    cyc(1'b1, gen ^ 8'h01, 1'b1, 1'b1);
    gen = mstep(gen);
    chk("clr_miss_count",   32'(dut_count), 32'd1);
    chk("clr_miss_s_count", 32'(sat_count), 32'd1);
    chk("clr_miss_error",   32'(dut_error), 32'd1);

    // Reset in the middle of lock
    cyc(1'b1, gen ^ 8'h80, 1'b0, 1'b1);
    gen = mstep(gen);
    chk("pre_rst_count", 32'(dut_count), 32'd2);
    cyc(1'b1, gen, 1'b0, 1'b0);
    gen = mstep(gen);
    chk("mid_rst_locked",   32'(dut_locked),   32'd0);
    chk("mid_rst_count",    32'(dut_count),    32'd0);
    chk("mid_rst_expected", 32'(dut_expected), 32'd0);
    chk("mid_rst_error",    32'(dut_error),    32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, gen, 1'b0, 1'b1);
      gen = mstep(gen);
      chk($sformatf("relock%0d", i), 32'(dut_locked), (i == 4) ? 32'd1 : 32'd0);
    end

    // Randomised stream with occasional corruption, zeros, clears and resets
    for (int n = 0; n < 800; n++) begin
      logic       v, c, rn;
      logic [7:0] d;
      int         sel;
      v   = ($urandom_range(0, 99) < 75);
      c   = ($urandom_range(0, 29) == 0);
      rn  = ($urandom_range(0, 199) != 0);
      sel = $urandom_range(0, 15);
      if (sel == 0)      d = 8'h00;
      else if (sel < 3)  d = 8'($urandom);
      else               d = gen;
      cyc(v, d, c, rn);
      if (v) gen = mstep(gen);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
